// File: rtl/pc_sequencer_if.sv
// Redirect request / fetch address bundle between the execute-stage
// redirect producers, the PC sequencer and instruction fetch.
interface pc_sequencer_if;
  logic        stall_i;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        jmp_req;
  logic [31:0] jmp_target;
  logic        br_req;
  logic [31:0] br_target;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        ignore_curr_inst;
  logic        redirect_taken;
  logic        misaligned_err;

  modport master (
    output stall_i, trap_req, trap_vec, jmp_req, jmp_target, br_req, br_target, fetch_ready,
    input  pc, fetch_valid, ignore_curr_inst, redirect_taken, misaligned_err
  );

  modport slave (
    input  stall_i, trap_req, trap_vec, jmp_req, jmp_target, br_req, br_target, fetch_ready,
    output pc, fetch_valid, ignore_curr_inst, redirect_taken, misaligned_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner: arbitrates trap/jump/branch redirects into one registered
// PC stream, parks redirects fetch cannot take, and squashes the wrong path.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  pc_sequencer_if.slave bus
);
  // state | meaning
  // BOOT  | first cycle out of reset, no fetch issued yet
  // RUN   | sequential fetch, redirect sources arbitrated
  // PEND  | redirect parked until fetch accepts it
  // FLUSH | redirect applied, wrong-path instructions squashed
  typedef enum logic [1:0] {BOOT, RUN, PEND, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        ign_q, ign_d;
  logic        rt_q, rt_d;
  logic        me_q, me_d;

  logic [31:0] jmp_al, br_al, pc_inc, win_tgt;
  logic        win_ok, win_bad;

  assign jmp_al = bus.jmp_target & ~32'd1;
  assign br_al  = bus.br_target & ~32'd1;
  assign pc_inc = pc_q + 32'd4;

  // A misaligned jmp/br still wins arbitration, so it blocks lower sources.
  always_comb begin
    win_ok  = 1'b0;
    win_bad = 1'b0;
    win_tgt = bus.trap_vec;
    if (bus.trap_req) begin
      win_ok = 1'b1;
    end else if (bus.jmp_req) begin
      win_tgt = jmp_al;
      win_ok  = ~jmp_al[1];
      win_bad = jmp_al[1];
    end else if (bus.br_req) begin
      win_tgt = br_al;
      win_ok  = ~br_al[1];
      win_bad = br_al[1];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    valid_d = 1'b1;
    ign_d   = 1'b0;
    rt_d    = 1'b0;
    me_d    = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        me_d = win_bad;
        if (win_ok) begin
          ign_d = 1'b1;
          if (bus.fetch_ready) begin
            pc_d    = win_tgt;
            rt_d    = 1'b1;
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
          end else begin
            pend_d  = win_tgt;
            state_d = PEND;
          end
        end else if (bus.fetch_ready && !bus.stall_i) begin
          pc_d = pc_inc;
        end
      end
      PEND: begin
        ign_d = 1'b1;
        if (bus.trap_req) pend_d = bus.trap_vec;
        if (bus.fetch_ready) begin
          pc_d    = bus.trap_req ? bus.trap_vec : pend_q;
          rt_d    = 1'b1;
          cnt_d   = FLUSH_LOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.trap_req) begin
          ign_d = 1'b1;
          if (bus.fetch_ready) begin
            pc_d  = bus.trap_vec;
            rt_d  = 1'b1;
            cnt_d = FLUSH_LOAD;
          end else begin
            pend_d  = bus.trap_vec;
            state_d = PEND;
          end
        end else begin
          if (bus.fetch_ready) pc_d = pc_inc;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
          else               ign_d   = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      ign_q   <= 1'b0;
      rt_q    <= 1'b0;
      me_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ign_q   <= ign_d;
      rt_q    <= rt_d;
      me_q    <= me_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.fetch_valid      = valid_q;
  assign bus.ignore_curr_inst = ign_q;
  assign bus.redirect_taken   = rt_q;
  assign bus.misaligned_err   = me_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random redirect traffic,
// checked every cycle against a deadline-based behavioural model.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam int          FLUSH_N = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: squash window expressed as the last cycle number that is squashed
  int          cyc = 0;
  int          shadow_end = -1;
  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ptgt = 32'd0;
  bit          m_rt = 1'b0;
  bit          m_me = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_redirect(input logic [31:0] t);
    if (bus.fetch_ready) begin
      m_pc       = t;
      m_rt       = 1'b1;
      shadow_end = cyc + FLUSH_N - 1;
    end else begin
      m_pend = 1'b1;
      m_ptgt = t;
    end
  endtask

  task automatic model_advance();
    if (bus.fetch_ready && !bus.stall_i) m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step();
    logic [31:0] t;
    bit          in_shadow;
    in_shadow = m_pend || (cyc <= shadow_end);
    cyc++;
    m_rt = 1'b0;
    m_me = 1'b0;
    if (!i_rst) begin
      m_pc = RST_PC; m_boot = 1'b1; m_pend = 1'b0; m_ptgt = 32'd0;
      shadow_end = cyc - 1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_pend) begin
      if (bus.trap_req) m_ptgt = bus.trap_vec;
      if (bus.fetch_ready) begin
        m_pend = 1'b0;
        model_redirect(m_ptgt);
      end
    end else if (in_shadow) begin
      if (bus.trap_req)         model_redirect(bus.trap_vec);
      else if (bus.fetch_ready) m_pc = m_pc + 32'd4;
    end else begin
      if (bus.trap_req) begin
        model_redirect(bus.trap_vec);
      end else if (bus.jmp_req || bus.br_req) begin
        t = bus.jmp_req ? bus.jmp_target : bus.br_target;
        t[0] = 1'b0;
        if (t[1]) begin
          m_me = 1'b1;
          model_advance();
        end else begin
          model_redirect(t);
        end
      end else begin
        model_advance();
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    #1;
    check("pc", bus.pc, m_pc);
    check("fetch_valid", 32'(bus.fetch_valid), 32'(!m_boot));
    check("ignore_curr_inst", 32'(bus.ignore_curr_inst), 32'(m_pend || (cyc <= shadow_end)));
    check("redirect_taken", 32'(bus.redirect_taken), 32'(m_rt));
    check("misaligned_err", 32'(bus.misaligned_err), 32'(m_me));
  endtask

  task automatic drive(input bit tr, input logic [31:0] tv, input bit jr, input logic [31:0] jt,
                       input bit brq, input logic [31:0] bt, input bit fr, input bit st);
    bus.trap_req = tr;  bus.trap_vec = tv;
    bus.jmp_req = jr;   bus.jmp_target = jt;
    bus.br_req = brq;   bus.br_target = bt;
    bus.fetch_ready = fr;
    bus.stall_i = st;
  endtask

  task automatic idle(input bit fr);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, fr, 1'b0);
  endtask

  initial begin
    logic [31:0] hold_pc;
    idle(1'b1);
    i_rst = 1'b0;
    step();
    check("rst_pc", bus.pc, RST_PC);
    check("rst_valid", 32'(bus.fetch_valid), 32'd0);

    // boot then sequential advance
    i_rst = 1'b1;
    step();
    check("boot_pc", bus.pc, 32'h100);
    check("boot_valid", 32'(bus.fetch_valid), 32'd1);
    step();
    check("seq_pc1", bus.pc, 32'h104);
    step();
    check("seq_pc2", bus.pc, 32'h108);

    // jump with bit0 set, two-cycle squash window
    drive(1'b0, 32'd0, 1'b1, 32'h2001, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    check("jmp_pc", bus.pc, 32'h2000);
    check("jmp_rt", 32'(bus.redirect_taken), 32'd1);
    check("jmp_ign1", 32'(bus.ignore_curr_inst), 32'd1);
    idle(1'b1);
    step();
    check("jmp_pc2", bus.pc, 32'h2004);
    check("jmp_ign2", 32'(bus.ignore_curr_inst), 32'd1);
    step();
    check("jmp_ign3", 32'(bus.ignore_curr_inst), 32'd0);

    // priority, then a jump inside the squash window is dropped
    drive(1'b1, 32'h80, 1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 1'b0);
    step();
    check("prio_pc", bus.pc, 32'h80);
    drive(1'b0, 32'd0, 1'b1, 32'h400, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    check("flush_jmp_pc", bus.pc, 32'h84);
    check("flush_jmp_rt", 32'(bus.redirect_taken), 32'd0);
    idle(1'b1);
    step();
    check("flush_exit_pc", bus.pc, 32'h88);

    // parked branch overtaken by a trap
    hold_pc = bus.pc;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h600, 1'b0, 1'b0);
    step();
    check("pend_hold1", bus.pc, hold_pc);
    check("pend_ign1", 32'(bus.ignore_curr_inst), 32'd1);
    drive(1'b1, 32'h90, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    check("pend_hold2", bus.pc, hold_pc);
    idle(1'b0);
    step();
    check("pend_hold3", bus.pc, hold_pc);
    check("pend_ign3", 32'(bus.ignore_curr_inst), 32'd1);
    idle(1'b1);
    step();
    check("pend_pc", bus.pc, 32'h90);
    check("pend_rt", 32'(bus.redirect_taken), 32'd1);
    step();
    step();

    // misaligned jump target rejected
    hold_pc = bus.pc;
    drive(1'b0, 32'd0, 1'b1, 32'h1002, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    check("mis_err", 32'(bus.misaligned_err), 32'd1);
    check("mis_pc", bus.pc, hold_pc + 32'd4);
    check("mis_ign", 32'(bus.ignore_curr_inst), 32'd0);
    idle(1'b1);
    step();
    check("mis_pulse", 32'(bus.misaligned_err), 32'd0);

    // address wrap in sequential run
    drive(1'b1, 32'hFFFF_FFF4, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    step();
    step();
    check("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", bus.pc, 32'h0000_0000);

    // reset while squashing
    drive(1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    i_rst = 1'b0;
    step();
    check("rstf_pc", bus.pc, RST_PC);
    check("rstf_ign", 32'(bus.ignore_curr_inst), 32'd0);
    check("rstf_valid", 32'(bus.fetch_valid), 32'd0);
    i_rst = 1'b1;
    step();

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tv, jt, bt;
      tv = $urandom;
      jt = $urandom;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) jt[1] = 1'b0;
      if ($urandom_range(0, 3) != 0) bt[1] = 1'b0;
      if ($urandom_range(0, 7) == 0) tv = 32'hFFFF_FFF0 | (tv & 32'hC);
      drive($urandom_range(0, 11) == 0, tv, $urandom_range(0, 5) == 0, jt,
            $urandom_range(0, 4) == 0, bt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      i_rst = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
